// File: rtl/tick_gen_64hz.sv
// rtl/tick_gen_64hz.sv - free-running slow-clock / tick generator with start/stop and resync
//
// Optional feature macro: TICK_GEN_SEC_EN (builds the phase counter and seconds strobe;
// when undefined, phase and sec_pulse are tied to 0).
//
// Parameters:
//   CLK_HZ    frequency of Clk in Hz
//   TICK_HZ   slow_clk frequency in Hz (DIV = CLK_HZ/TICK_HZ must be >= 2)
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   run        in   level: 1 = generate periods, 0 = stop at end of current period
//   sync       in   one-cycle synchronous restart strobe (returns to IDLE)
//   slow_clk   out  registered square wave, HI cycles high then LO cycles low
//   tick       out  registered strobe on the first cycle of each high phase
//   busy       out  high whenever the state machine is not IDLE
//   phase      out  ticks emitted modulo 64
//   sec_pulse  out  strobe coincident with the tick that wraps phase 63 -> 0

module tick_gen_64hz #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 64
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       run,
    input  logic       sync,
    output logic       slow_clk,
    output logic       tick,
    output logic       busy,
    output logic [5:0] phase,
    output logic       sec_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int HI  = DIV / 2;
    localparam int LO  = DIV - HI;
    // LO >= HI always, so a counter sized for LO-1 also holds HI-1.
    localparam int CW  = (LO > 1) ? $clog2(LO) : 1;

    localparam logic [CW-1:0] HI_LOAD = CW'(HI - 1);
    localparam logic [CW-1:0] LO_LOAD = CW'(LO - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_gen_64hz: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          slow_nxt;
    logic          tick_nxt;
    logic          start;
    // Held low for the first edge after reset release so that a period never
    // starts on the very edge that follows Reset_n deassertion.
    logic          armed;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            slow_clk <= 1'b0;
            tick     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            slow_clk <= slow_nxt;
            tick     <= tick_nxt;
            armed    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slow_nxt  = slow_clk;
        tick_nxt  = 1'b0;
        start     = 1'b0;

        case (state)
            ST_IDLE: begin
                slow_nxt = 1'b0;
                cnt_nxt  = '0;
                if (run && armed) begin
                    start = 1'b1;
                end
            end
            ST_HIGH: begin
                // run is deliberately ignored here: a started period always completes.
                if (cnt == '0) begin
                    state_nxt = ST_LOW;
                    slow_nxt  = 1'b0;
                    cnt_nxt   = LO_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (cnt == '0) begin
                    if (run) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                slow_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase

        if (start) begin
            state_nxt = ST_HIGH;
            slow_nxt  = 1'b1;
            tick_nxt  = 1'b1;
            cnt_nxt   = HI_LOAD;
        end

        // Restart wins over run and over the end-of-period transition.
        if (sync) begin
            state_nxt = ST_IDLE;
            slow_nxt  = 1'b0;
            tick_nxt  = 1'b0;
            cnt_nxt   = '0;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef TICK_GEN_SEC_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase     <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            if (sync) begin
                phase <= '0;
            end else if (tick_nxt) begin
                phase     <= phase + 6'd1;
                sec_pulse <= (phase == 6'd63);
            end
        end
    end
`else
    assign phase     = '0;
    assign sec_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_tick_gen_64hz.sv
// tb/tb_tick_gen_64hz.sv - directed self-checking bench for tick_gen_64hz

module tb_tick_gen_64hz;

`ifdef TICK_GEN_SEC_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif

    logic       Clk;
    logic       Reset_n;
    logic       run_a, sync_a, run_b, sync_b;
    logic       slow_a, tick_a, busy_a, sec_a;
    logic       slow_b, tick_b, busy_b, sec_b;
    logic [5:0] phase_a, phase_b;

    int n_vec;
    int n_err;
    int ph;

    // DIV=16, HI=8, LO=8
    tick_gen_64hz #(.CLK_HZ(1024), .TICK_HZ(64)) u_dut_a (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .run       (run_a),
        .sync      (sync_a),
        .slow_clk  (slow_a),
        .tick      (tick_a),
        .busy      (busy_a),
        .phase     (phase_a),
        .sec_pulse (sec_a)
    );

    // DIV=5, HI=2, LO=3
    tick_gen_64hz #(.CLK_HZ(320), .TICK_HZ(64)) u_dut_b (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .run       (run_b),
        .sync      (sync_b),
        .slow_clk  (slow_b),
        .tick      (tick_b),
        .busy      (busy_b),
        .phase     (phase_b),
        .sec_pulse (sec_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        Reset_n = 1'b0;
        run_a   = 1'b0;
        sync_a  = 1'b0;
        run_b   = 1'b0;
        sync_b  = 1'b0;
        repeat (2) step();

        expect_eq("rst_slow_a", 32'(slow_a), 32'd0);
        expect_eq("rst_tick_a", 32'(tick_a), 32'd0);
        expect_eq("rst_busy_a", 32'(busy_a), 32'd0);
        expect_eq("rst_phase_a", 32'(phase_a), 32'd0);
        expect_eq("rst_sec_a", 32'(sec_a), 32'd0);
        expect_eq("rst_slow_b", 32'(slow_b), 32'd0);
        expect_eq("rst_busy_b", 32'(busy_b), 32'd0);

        #2 Reset_n = 1'b1;
        step();
        step();
        expect_eq("idle_busy_a", 32'(busy_a), 32'd0);
        expect_eq("idle_tick_a", 32'(tick_a), 32'd0);

        // DIV=5 free-running: 1,1,0,0,0 with ticks every 5 cycles
        run_b = 1'b1;
        step();
        for (int i = 0; i < 25; i++) begin
            expect_eq("b_slow", 32'(slow_b), 32'((i % 5) < 2));
            expect_eq("b_tick", 32'(tick_b), 32'((i % 5) == 0));
            expect_eq("b_busy", 32'(busy_b), 32'd1);
            step();
        end
        run_b = 1'b0;

        // DIV=16: 1-cycle latency, 8 high / 8 low, run dropped 3 cycles into 4th HIGH
        run_a = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            expect_eq("a_slow", 32'(slow_a), 32'((i % 16) < 8));
            expect_eq("a_tick", 32'(tick_a), 32'((i % 16) == 0));
            expect_eq("a_busy", 32'(busy_a), 32'd1);
            if (i == 51) run_a = 1'b0;
            step();
        end
        expect_eq("stop_busy", 32'(busy_a), 32'd0);
        expect_eq("stop_phase", 32'(phase_a), SEC_EN ? 32'd4 : 32'd0);
        for (int i = 0; i < 5; i++) begin
            expect_eq("stop_slow", 32'(slow_a), 32'd0);
            expect_eq("stop_tick", 32'(tick_a), 32'd0);
            step();
        end

        // sync in IDLE clears phase
        sync_a = 1'b1;
        step();
        sync_a = 1'b0;
        expect_eq("sync_idle_phase", 32'(phase_a), 32'd0);

        // 64 periods: phase 1..63,0 and a single sec_pulse on the 64th tick
        run_a = 1'b1;
        step();
        ph = 0;
        for (int i = 0; i < 1024; i++) begin
            if ((i % 16) == 0) ph = (ph + 1) % 64;
            expect_eq("p_slow", 32'(slow_a), 32'((i % 16) < 8));
            expect_eq("p_tick", 32'(tick_a), 32'((i % 16) == 0));
            expect_eq("p_sec", 32'(sec_a), 32'(SEC_EN && ((i % 16) == 0) && (ph == 0)));
            if ((i % 16) == 0)
                expect_eq("p_phase", 32'(phase_a), SEC_EN ? 32'(ph) : 32'd0);
            step();
        end

        // sync mid-LOW with run=1
        repeat (10) step();
        expect_eq("pre_sync_slow", 32'(slow_a), 32'd0);
        sync_a = 1'b1;
        step();
        sync_a = 1'b0;
        expect_eq("sync_busy", 32'(busy_a), 32'd0);
        expect_eq("sync_slow", 32'(slow_a), 32'd0);
        expect_eq("sync_tick", 32'(tick_a), 32'd0);
        expect_eq("sync_phase", 32'(phase_a), 32'd0);
        step();
        expect_eq("resync_slow", 32'(slow_a), 32'd1);
        expect_eq("resync_tick", 32'(tick_a), 32'd1);
        expect_eq("resync_phase", 32'(phase_a), SEC_EN ? 32'd1 : 32'd0);

        // sync on the last LOW cycle beats the period-end restart
        repeat (15) step();
        expect_eq("last_low_busy", 32'(busy_a), 32'd1);
        expect_eq("last_low_slow", 32'(slow_a), 32'd0);
        sync_a = 1'b1;
        step();
        sync_a = 1'b0;
        expect_eq("sync_end_busy", 32'(busy_a), 32'd0);
        expect_eq("sync_end_slow", 32'(slow_a), 32'd0);
        expect_eq("sync_end_tick", 32'(tick_a), 32'd0);
        step();
        expect_eq("sync_end_restart", 32'(tick_a), 32'd1);

        // async reset pulse during HIGH
        repeat (3) step();
        expect_eq("pre_rst_slow", 32'(slow_a), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        expect_eq("arst_slow", 32'(slow_a), 32'd0);
        expect_eq("arst_tick", 32'(tick_a), 32'd0);
        expect_eq("arst_busy", 32'(busy_a), 32'd0);
        expect_eq("arst_phase", 32'(phase_a), 32'd0);
        expect_eq("arst_sec", 32'(sec_a), 32'd0);
        #2 Reset_n = 1'b1;
        step();
        expect_eq("rel_edge1_tick", 32'(tick_a), 32'd0);
        expect_eq("rel_edge1_busy", 32'(busy_a), 32'd0);
        step();
        expect_eq("rel_edge2_tick", 32'(tick_a), 32'd1);
        expect_eq("rel_edge2_slow", 32'(slow_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
